dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Synthesizable DRAM device model that sits on the far side of the RAS/MUX/CAS strobe interface.
- Decodes the active-low strobes from the memory controller and latches the row address on the RAS fall and the column address on the CAS fall.
- Performs a read or write on an internal array and supports CAS-before-RAS (CBR) refresh.
- Used as the bench/board-level target for the controller and as an on-chip scratch memory.

Parameters:
- ROW_BITS, 4, row address width.
- COL_BITS, 4, column address width.
- ADDR_BITS, max(ROW_BITS,COL_BITS)=4, width of the multiplexed address bus.
- DATA_WIDTH, 8, data word width.
- PRECHARGE_CYCLES, 1, minimum cycles RAS must stay high before the next row open.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- ras_in  input  1  row strobe, active low.
- mux_in  input  1  address-select indication: 0 = row on addr_in, 1 = column on addr_in.
- cas_in  input  1  column strobe, active low.
- we_in  input  1  1 = write, 0 = read; sampled on the CAS fall.
- addr_in  input  ADDR_BITS  multiplexed row/column address.
- data_in  input  DATA_WIDTH  write data; sampled on the CAS fall.
- data_out  output  DATA_WIDTH  read data.
- data_valid_out  output  1  data_out holds valid read data.
- refresh_row_out  output  ROW_BITS  internal refresh row counter.
- error_out  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous):
  - State = IDLE.
  - Previous-strobe registers ras_q = 1 and cas_q = 1.
  - data_out = 0, data_valid_out = 0, refresh_row_out = 0, error_out = 0.
  - Array contents are not reset.
- Edge detection:
  - ras_fall = ras_q & ~ras_in; ras_rise = ~ras_q & ras_in. cas_fall and cas_rise are defined the same way.
  - Strobes are sampled synchronously; the minimum pulse width is one cycle.
- States:
  - IDLE
    - ras_fall with cas_in = 1: latch row = addr_in[ROW_BITS-1:0] and go to ROW_OPEN. If mux_in = 1 at the fall, set error_out.
    - cas_fall with ras_in = 1: go to CBR_ARMED.
  - ROW_OPEN
    - cas_fall: latch col = addr_in[COL_BITS-1:0] and go to ACCESS. If mux_in = 0 at the fall, set error_out.
    - Write (we_in = 1): array[{row,col}] <= data_in in that same cycle.
    - Read (we_in = 0): data_out <= array[{row,col}] and data_valid_out = 1 from the next cycle.
    - ras_rise without any CAS: go to PRECHARGE (row closed, no access).
  - ACCESS
    - Hold data_out and data_valid_out while cas_in = 0.
    - cas_rise: clear data_valid_out and return to ROW_OPEN. Page mode is allowed: a further cas_fall performs a new access on the same row.
    - ras_rise while cas_in = 0: clear data_valid_out and go to PRECHARGE.
  - CBR_ARMED
    - ras_fall: refresh_row_out increments, wrapping from 2^ROW_BITS-1 to 0. No array access. Go to REFRESH.
    - cas_rise before ras_fall: return to IDLE with no effect.
  - REFRESH
    - Wait until both ras_in and cas_in are 1, then go to PRECHARGE.
  - PRECHARGE
    - Counter loads PRECHARGE_CYCLES on entry.
    - Go to IDLE when the counter reaches 0 and ras_in = 1.
    - ras_fall while the counter is nonzero: set error_out, ignore the access, and stay in PRECHARGE until RAS is high again.
- Latencies against the controller sequence (ras low 4 cycles, mux high at cycle 2, cas low cycles 3–4):
  - Read data is valid on the cycle after the CAS fall is sampled and stays valid until cas_in is sampled high.
  - The controller's single high-RAS idle cycle satisfies PRECHARGE_CYCLES = 1.
- Simultaneous events:
  - ras_fall and cas_fall in the same cycle from IDLE: treat as a row open (CAS is ignored that cycle) and set error_out.
  - ras_rise and cas_fall in the same cycle: no access.
- error_out clears only on rst_in.
- Reset asserted mid-access: outputs return immediately to their reset values. A write whose CAS-fall edge has not yet been clocked is not performed.

Decomposition:
- Shared package dram_pkg holds:
  - state encodings (IDLE, ROW_OPEN, ACCESS, CBR_ARMED, REFRESH, PRECHARGE);
  - strobe polarity constants (STROBE_ACTIVE = 0).
- One natural sub-module: dram_strobe_edge, which registers one strobe and emits fall/rise pulses. It is instantiated twice (RAS and CAS).

Test Plan:
- Write then read:
  - Controller-style write: row 3 with mux_in = 0, col 5 with mux_in = 1, we_in = 1, data_in = 8'hA5.
  - Later read of {3,5} → data_out = 8'hA5 with data_valid_out high on the cycle after the CAS fall, low after the CAS rise. error_out stays 0.
- Page mode:
  - One RAS low (row 7) with two CAS pulses reading cols 0 and 1, after prior writes of 8'h11 and 8'h22.
  - → data_out = 8'h11, then 8'h22.
- CBR refresh:
  - Three CAS-fall-then-RAS-fall sequences → refresh_row_out goes 0→1→2→3. Array contents are unchanged, verified by readback.
- Refresh wrap:
  - 16 CBR cycles with ROW_BITS = 4 → refresh_row_out returns to 0.
- Protocol errors:
  - RAS fall with mux_in = 1 → error_out = 1 and stays 1 afterwards.
  - Separately, with PRECHARGE_CYCLES = 3, RAS falls one cycle after it rises → error_out = 1 and the access is ignored (the target word is unchanged).
- Reset mid-read:
  - Assert rst_in while data_valid_out = 1 → data_valid_out = 0 and data_out = 0 immediately.
  - After release, a new access works normally.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared state encodings and strobe polarity for the DRAM responder model.
package dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW_OPEN,
    ST_ACCESS,
    ST_CBR_ARMED,
    ST_REFRESH,
    ST_PRECHARGE
  } state_t;

  localparam logic STROBE_ACTIVE = 1'b0;

endpackage

// File: rtl/dram_if.sv
// RAS/MUX/CAS strobe bus between a memory controller (master) and the DRAM model (slave).
interface dram_if #(
  parameter int ROW_BITS   = 4,
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  ras_in;
  logic                  mux_in;
  logic                  cas_in;
  logic                  we_in;
  logic [ADDR_BITS-1:0]  addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid_out;
  logic [ROW_BITS-1:0]   refresh_row_out;
  logic                  error_out;

  modport master (
    output ras_in, mux_in, cas_in, we_in, addr_in, data_in,
    input  data_out, data_valid_out, refresh_row_out, error_out
  );

  modport slave (
    input  ras_in, mux_in, cas_in, we_in, addr_in, data_in,
    output data_out, data_valid_out, refresh_row_out, error_out
  );
endinterface

// File: rtl/dram_strobe_edge.sv
// Registers one active-low strobe and flags its assert (fall) and release (rise) edges.
module dram_strobe_edge
  import dram_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic strobe_in,
  output logic fall_out,
  output logic rise_out
);

  logic strobe_q;
  logic strobe_d;

  assign strobe_d = strobe_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) strobe_q <= ~STROBE_ACTIVE;
    else        strobe_q <= strobe_d;
  end

  assign fall_out = (strobe_q != STROBE_ACTIVE) && (strobe_in == STROBE_ACTIVE);
  assign rise_out = (strobe_q == STROBE_ACTIVE) && (strobe_in != STROBE_ACTIVE);

endmodule

// File: rtl/dram_responder.sv
// DRAM device model: decodes RAS/MUX/CAS strobes, services reads/writes on an internal
// array and counts CAS-before-RAS refreshes. States: IDLE | ROW_OPEN | ACCESS | CBR_ARMED | REFRESH | PRECHARGE.
module dram_responder
  import dram_pkg::*;
#(
  parameter int ROW_BITS         = 4,
  parameter int COL_BITS         = 4,
  parameter int ADDR_BITS        = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS,
  parameter int DATA_WIDTH       = 8,
  parameter int PRECHARGE_CYCLES = 1
) (
  input  logic   clk_in,
  input  logic   rst_in,
  dram_if.slave  bus
);

  localparam int CNT_W = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
  // The RAS-rise cycle itself is the first precharge cycle, so the count starts one lower.
  localparam logic [CNT_W-1:0] PC_LOAD = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam int MEM_DEPTH = 2 ** (ROW_BITS + COL_BITS);

  state_t                   state_q, state_d;
  logic [ROW_BITS-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic [ROW_BITS-1:0]      refresh_q, refresh_d;
  logic                     error_q, error_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
  logic                     mem_we;
  logic [ROW_BITS+COL_BITS-1:0] mem_addr;

  logic ras_fall, ras_rise, cas_fall, cas_rise;
  logic ready;

  dram_strobe_edge u_ras_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .strobe_in (bus.ras_in),
    .fall_out  (ras_fall),
    .rise_out  (ras_rise)
  );

  dram_strobe_edge u_cas_edge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .strobe_in (bus.cas_in),
    .fall_out  (cas_fall),
    .rise_out  (cas_rise)
  );

  assign mem_addr = {row_q, bus.addr_in[COL_BITS-1:0]};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    data_d    = data_q;
    valid_d   = valid_q;
    refresh_d = refresh_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    // A finished precharge behaves exactly like IDLE so a back-to-back row open is accepted.
    ready     = (state_q == ST_IDLE) || ((state_q == ST_PRECHARGE) && (cnt_q == '0));

    if (ready) begin
      if (ras_fall) begin
        row_d   = bus.addr_in[ROW_BITS-1:0];
        state_d = ST_ROW_OPEN;
        if (bus.mux_in || !bus.cas_in) error_d = 1'b1;
      end else if (cas_fall && bus.ras_in) begin
        state_d = ST_CBR_ARMED;
      end else if (bus.ras_in) begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_ROW_OPEN: begin
          if (ras_rise) begin
            state_d = ST_PRECHARGE;
            cnt_d   = PC_LOAD;
          end else if (cas_fall) begin
            state_d = ST_ACCESS;
            if (!bus.mux_in) error_d = 1'b1;
            if (bus.we_in) begin
              mem_we = !rst_in;
            end else begin
              data_d  = mem[mem_addr];
              valid_d = 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (ras_rise) begin
            valid_d = 1'b0;
            state_d = ST_PRECHARGE;
            cnt_d   = PC_LOAD;
          end else if (cas_rise) begin
            valid_d = 1'b0;
            state_d = ST_ROW_OPEN;
          end
        end
        ST_CBR_ARMED: begin
          if (ras_fall) begin
            refresh_d = refresh_q + ROW_BITS'(1);
            state_d   = ST_REFRESH;
          end else if (cas_rise) begin
            state_d = ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (bus.ras_in && bus.cas_in) begin
            state_d = ST_PRECHARGE;
            cnt_d   = PC_LOAD;
          end
        end
        ST_PRECHARGE: begin
          // Early RAS fall: flag it and wait for RAS to return high before timing again.
          if (ras_fall) begin
            error_d = 1'b1;
          end else if (ras_rise) begin
            cnt_d = PC_LOAD;
          end else if (bus.ras_in && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      refresh_q <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      refresh_q <= refresh_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_addr] <= bus.data_in;
  end

  assign bus.data_out        = data_q;
  assign bus.data_valid_out  = valid_q;
  assign bus.refresh_row_out = refresh_q;
  assign bus.error_out       = error_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: a vector table for write/read/page mode plus hand
// sequences for CBR refresh, refresh wrap, protocol errors and reset mid-read.
module tb_dram_responder;

  localparam int RB = 4;
  localparam int CB = 4;
  localparam int AB = 4;
  localparam int DW = 8;
  localparam int NV = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dram_if #(.ROW_BITS(RB), .ADDR_BITS(AB), .DATA_WIDTH(DW)) bus_a ();
  dram_if #(.ROW_BITS(RB), .ADDR_BITS(AB), .DATA_WIDTH(DW)) bus_b ();

  dram_responder #(.ROW_BITS(RB), .COL_BITS(CB), .ADDR_BITS(AB), .DATA_WIDTH(DW),
                   .PRECHARGE_CYCLES(1)) dut_a (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_a.slave)
  );

  dram_responder #(.ROW_BITS(RB), .COL_BITS(CB), .ADDR_BITS(AB), .DATA_WIDTH(DW),
                   .PRECHARGE_CYCLES(3)) dut_b (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_b.slave)
  );

  typedef struct {
    logic       ras;
    logic       mux;
    logic       cas;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic       valid;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(int ras, int mux, int cas, int we, int addr, int din,
                              int v, int q);
    vec_t r;
    r.ras   = ras[0];
    r.mux   = mux[0];
    r.cas   = cas[0];
    r.we    = we[0];
    r.addr  = addr[3:0];
    r.din   = din[7:0];
    r.valid = v[0];
    r.dout  = q[7:0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one input vector to the selected bus across one rising edge, then settle.
  task automatic step(input bit b, input int ras, input int mux, input int cas, input int we,
                      input int addr, input int din);
    @(negedge clk);
    if (!b) begin
      bus_a.ras_in  = ras[0];
      bus_a.mux_in  = mux[0];
      bus_a.cas_in  = cas[0];
      bus_a.we_in   = we[0];
      bus_a.addr_in = addr[3:0];
      bus_a.data_in = din[7:0];
    end else begin
      bus_b.ras_in  = ras[0];
      bus_b.mux_in  = mux[0];
      bus_b.cas_in  = cas[0];
      bus_b.we_in   = we[0];
      bus_b.addr_in = addr[3:0];
      bus_b.data_in = din[7:0];
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int vld(input bit b);
    return b ? int'(bus_b.data_valid_out) : int'(bus_a.data_valid_out);
  endfunction

  function automatic int dat(input bit b);
    return b ? int'(bus_b.data_out) : int'(bus_a.data_out);
  endfunction

  task automatic wr(input bit b, input int r, input int c, input int d);
    step(b, 0, 0, 1, 0, r, 0);
    step(b, 0, 1, 1, 0, c, 0);
    step(b, 0, 1, 0, 1, c, d);
    step(b, 0, 1, 0, 1, c, d);
    step(b, 1, 0, 1, 0, 0, 0);
  endtask

  task automatic rd(input bit b, input int r, input int c, input int exp, input string nm);
    step(b, 0, 0, 1, 0, r, 0);
    step(b, 0, 1, 1, 0, c, 0);
    step(b, 0, 1, 0, 0, c, 0);
    chk({nm, " valid"}, vld(b), 1);
    chk({nm, " data"}, dat(b), exp);
    step(b, 0, 1, 0, 0, c, 0);
    chk({nm, " hold"}, dat(b), exp);
    step(b, 1, 0, 1, 0, 0, 0);
    chk({nm, " valid_clr"}, vld(b), 0);
  endtask

  task automatic cbr(input int exp_ref);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk($sformatf("cbr ref%0d", exp_ref), int'(bus_a.refresh_row_out), exp_ref);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
  endtask

  initial begin
    bus_a.ras_in = 1'b1; bus_a.mux_in = 1'b0; bus_a.cas_in = 1'b1; bus_a.we_in = 1'b0;
    bus_a.addr_in = '0;  bus_a.data_in = '0;
    bus_b.ras_in = 1'b1; bus_b.mux_in = 1'b0; bus_b.cas_in = 1'b1; bus_b.we_in = 1'b0;
    bus_b.addr_in = '0;  bus_b.data_in = '0;

    tbl[0]  = mk(0, 0, 1, 0, 3, 'h00, 0, 'h00);
    tbl[1]  = mk(0, 1, 1, 0, 5, 'h00, 0, 'h00);
    tbl[2]  = mk(0, 1, 0, 1, 5, 'hA5, 0, 'h00);
    tbl[3]  = mk(0, 1, 0, 1, 5, 'hA5, 0, 'h00);
    tbl[4]  = mk(1, 0, 1, 0, 0, 'h00, 0, 'h00);
    tbl[5]  = mk(0, 0, 1, 0, 3, 'h00, 0, 'h00);
    tbl[6]  = mk(0, 1, 1, 0, 5, 'h00, 0, 'h00);
    tbl[7]  = mk(0, 1, 0, 0, 5, 'h00, 1, 'hA5);
    tbl[8]  = mk(0, 1, 0, 0, 5, 'h00, 1, 'hA5);
    tbl[9]  = mk(0, 1, 1, 0, 5, 'h00, 0, 'h00);
    tbl[10] = mk(1, 0, 1, 0, 0, 'h00, 0, 'h00);
    tbl[11] = mk(0, 0, 1, 0, 7, 'h00, 0, 'h00);
    tbl[12] = mk(0, 1, 1, 0, 0, 'h00, 0, 'h00);
    tbl[13] = mk(0, 1, 0, 1, 0, 'h11, 0, 'h00);
    tbl[14] = mk(0, 1, 0, 1, 0, 'h11, 0, 'h00);
    tbl[15] = mk(1, 0, 1, 0, 0, 'h00, 0, 'h00);
    tbl[16] = mk(0, 0, 1, 0, 7, 'h00, 0, 'h00);
    tbl[17] = mk(0, 1, 1, 0, 1, 'h00, 0, 'h00);
    tbl[18] = mk(0, 1, 0, 1, 1, 'h22, 0, 'h00);
    tbl[19] = mk(0, 1, 0, 1, 1, 'h22, 0, 'h00);
    tbl[20] = mk(1, 0, 1, 0, 0, 'h00, 0, 'h00);
    tbl[21] = mk(0, 0, 1, 0, 7, 'h00, 0, 'h00);
    tbl[22] = mk(0, 1, 1, 0, 0, 'h00, 0, 'h00);
    tbl[23] = mk(0, 1, 0, 0, 0, 'h00, 1, 'h11);
    tbl[24] = mk(0, 1, 1, 0, 0, 'h00, 0, 'h00);
    tbl[25] = mk(0, 1, 0, 0, 1, 'h00, 1, 'h22);
    tbl[26] = mk(0, 1, 0, 0, 1, 'h00, 1, 'h22);
    tbl[27] = mk(1, 0, 1, 0, 0, 'h00, 0, 'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst valid", int'(bus_a.data_valid_out), 0);
    chk("rst data", int'(bus_a.data_out), 0);
    chk("rst refresh", int'(bus_a.refresh_row_out), 0);
    chk("rst error", int'(bus_a.error_out), 0);
    chk("rst error_b", int'(bus_b.error_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Write, read and page-mode table on the PRECHARGE_CYCLES = 1 instance.
    for (int i = 0; i < NV; i++) begin
      step(0, tbl[i].ras, tbl[i].mux, tbl[i].cas, tbl[i].we, tbl[i].addr, tbl[i].din);
      chk($sformatf("vec%0d valid", i), int'(bus_a.data_valid_out), int'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d data", i), int'(bus_a.data_out), int'(tbl[i].dout));
      chk($sformatf("vec%0d error", i), int'(bus_a.error_out), 0);
    end

    // CBR refresh counts up and leaves the array untouched.
    cbr(1);
    cbr(2);
    cbr(3);
    rd(0, 3, 5, 'hA5, "cbr rb35");
    rd(0, 7, 0, 'h11, "cbr rb70");
    rd(0, 7, 1, 'h22, "cbr rb71");
    chk("cbr error", int'(bus_a.error_out), 0);

    for (int i = 4; i <= 16; i++) cbr(i % 16);
    chk("wrap refresh", int'(bus_a.refresh_row_out), 0);

    // Reset while read data is valid: outputs drop before the next clock edge.
    step(0, 0, 0, 1, 0, 3, 0);
    step(0, 0, 1, 1, 0, 5, 0);
    step(0, 0, 1, 0, 0, 5, 0);
    chk("midrst pre valid", int'(bus_a.data_valid_out), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst valid", int'(bus_a.data_valid_out), 0);
    chk("midrst data", int'(bus_a.data_out), 0);
    @(negedge clk);
    bus_a.ras_in = 1'b1;
    bus_a.cas_in = 1'b1;
    bus_a.mux_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(0, 3, 5, 'hA5, "postrst rd");
    chk("postrst error", int'(bus_a.error_out), 0);

    // PRECHARGE_CYCLES = 3: RAS falls one cycle after rising, so the access is dropped.
    wr(1, 2, 4, 'h3C);
    chk("pc3 pre error", int'(bus_b.error_out), 0);
    step(1, 0, 0, 1, 0, 2, 0);
    chk("pc3 early fall", int'(bus_b.error_out), 1);
    step(1, 0, 1, 1, 0, 4, 0);
    step(1, 0, 1, 0, 1, 4, 'hFF);
    chk("pc3 ignored valid", int'(bus_b.data_valid_out), 0);
    step(1, 0, 1, 0, 1, 4, 'hFF);
    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0);
    rd(1, 2, 4, 'h3C, "pc3 rb");
    chk("pc3 sticky", int'(bus_b.error_out), 1);

    // RAS fall with MUX indicating column is a protocol error, and it is sticky.
    step(0, 0, 1, 1, 0, 2, 0);
    chk("mux err", int'(bus_a.error_out), 1);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    chk("mux err sticky", int'(bus_a.error_out), 1);
    rd(0, 7, 1, 'h22, "mux err rd");
    chk("mux err final", int'(bus_a.error_out), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
